status_reg_ctrl: RTL and testbench
==================================

// Module: status_reg_ctrl
// PURPOSE
//  Holds the architectural NZCV status register that feeds the condition-check stage.
//  Commits flags from flag-setting (S=1) instructions that pass their condition check,
//  including multi-cycle producers (e.g. multiply).
//  Provides an EX->ID bypassed flag view and raises a stall while flags are still pending.
//  Sits between the EX stage and the ID-stage condition check.
// PARAMETERS
//  FLAG_W   4  status width, packed {C,V,N,Z} (bit3=C, bit2=V, bit1=N, bit0=Z); fixed at 4
//  MC_TMO   8  max cycles to wait for a multi-cycle flag result before timeout
//  BYPASS   1  1: forward in-flight single-cycle flags to sr_fwd; 0: stall instead
// PORTS
//  clk           in   1  clock, rising-edge
//  rst_n         in   1  asynchronous active-low reset
//  ex_valid      in   1  EX stage holds a valid instruction
//  ex_s          in   1  instruction's S bit (updates flags)
//  ex_cond_pass  in   1  instruction passed its condition check
//  ex_multi      in   1  flags come from the multi-cycle unit, not ex_flags
//  ex_flags      in   4  single-cycle ALU flags {C,V,N,Z}
//  mc_done       in   1  multi-cycle unit result valid (1-cycle pulse)
//  mc_flags      in   4  multi-cycle unit flags; valid only with mc_done
//  msr_we        in   1  direct status write (MSR-style)
//  msr_data      in   4  data for msr_we
//  flush         in   1  pipeline flush from branch taken
//  id_uses_flags in   1  ID instruction's cond != AL (4'b1110/4'b1111)
//  sr_q          out  4  architectural status register
//  sr_fwd        out  4  flags presented to condition check (bypassed)
//  flag_stall    out  1  hold ID/IF; flags not yet available
//  busy          out  1  state==WAIT
//  err_tmo       out  1  1-cycle pulse on multi-cycle timeout
// BEHAVIOUR
//  Reset (async, rst_n=0): sr_q=4'b0, state=IDLE, tmo_cnt=0, flag_stall=0, busy=0, err_tmo=0.
//  upd = ex_valid & ex_s & ex_cond_pass & ~flush.
//  IDLE, priority highest first:
//    msr_we  -> sr_q<=msr_data.
//    upd&~ex_multi -> sr_q<=ex_flags.
//    upd&ex_multi  -> WAIT; tmo_cnt<=MC_TMO.
//   Write latency: 1 cycle.
//   If msr_we and upd&ex_multi coincide: sr_q<=msr_data and WAIT is entered.
//  WAIT:
//    mc_done -> sr_q<=mc_flags; -> IDLE.
//    flush   -> IDLE; sr_q unchanged; pending result dropped; later mc_done ignored.
//    msr_we  -> sr_q<=msr_data; -> IDLE; pending result discarded.
//    tmo_cnt==1 & ~mc_done -> err_tmo=1 for 1 cycle; -> IDLE; sr_q unchanged.
//    otherwise tmo_cnt decrements.
//   Priority: mc_done > flush > msr_we > timeout.
//   ex_* inputs are ignored in WAIT; upstream holds EX via flag_stall.
//  sr_fwd (combinational):
//    IDLE: msr_we ? msr_data : (BYPASS & upd & ~ex_multi) ? ex_flags : sr_q.
//    WAIT: mc_done ? mc_flags : sr_q.
//  flag_stall (combinational) = id_uses_flags & (
//    (WAIT & ~mc_done) | (IDLE & upd & ex_multi) | (~BYPASS & IDLE & upd & ~ex_multi)).
//  mc_done in IDLE: ignored (no state/sr change).
//  Reset mid-WAIT: immediate return to IDLE with sr_q=0.
// STRUCTURE
//  arm_pkg: FLAG_C=3, FLAG_V=2, FLAG_N=1, FLAG_Z=0 indices; typedef enum {SR_IDLE,SR_WAIT} sr_state_t;
//   COND_AL=4'b1110 constant.
//  One sub-module: sr_tmo_counter (load/decrement/expire, width $clog2(MC_TMO+1)).
//  FSM + sr_q register + bypass mux in the top module.
// TESTING
//  1 Reset: rst_n=0 mid-cycle -> sr_q=0, sr_fwd=0, flag_stall=0, busy=0 immediately.
//  2 ALU update: upd, ex_flags=4'b0101, id_uses_flags=1 -> sr_fwd=4'b0101 same cycle,
//    no stall; sr_q=4'b0101 next edge.
//  3 Cond fail / flush: ex_s=1, ex_cond_pass=0 (or flush=1), ex_flags=4'hF -> sr_q unchanged.
//  4 Multi-cycle: upd&ex_multi, id_uses_flags=1 -> stall cycles until mc_done(mc_flags=4'b1000);
//    sr_fwd=4'b1000 on the done cycle; sr_q=4'b1000 and IDLE next edge.
//  5 Timeout: MC_TMO=8, no mc_done -> err_tmo pulses 8 cycles after entering WAIT;
//    sr_q unchanged; busy=0.
//  6 Priority: IDLE with msr_we=1 (msr_data=4'b0011) and upd (ex_flags=4'b1100)
//    -> sr_q=4'b0011. BYPASS=0 run: upd with id_uses_flags -> flag_stall=1 for 1 cycle.

Source files
------------

// File: rtl/arm_pkg.sv
// arm_pkg: shared status-flag indices, condition constants and status FSM states
package arm_pkg;
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;
    localparam logic [3:0] COND_AL = 4'b1110;
    typedef enum logic {SR_IDLE, SR_WAIT} sr_state_t;
endpackage

// File: rtl/sr_tmo_counter.sv
// sr_tmo_counter: loadable down-counter that flags the last cycle of a multi-cycle wait
module sr_tmo_counter #(
    parameter int MC_TMO = 8,
    parameter int CNT_W  = $clog2(MC_TMO + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt_q,
    output logic             expire
);
    logic [CNT_W-1:0] cnt_d;
    // load takes priority; decrement stops at zero
    always_comb begin
        cnt_d = load ? CNT_W'(MC_TMO) : (dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end
    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign expire = cnt_q == CNT_W'(1);
endmodule

// File: rtl/status_reg_ctrl.sv
// status_reg_ctrl: NZCV status register with multi-cycle wait, EX->ID bypass and flag stall
module status_reg_ctrl
    import arm_pkg::*;
#(
    parameter int FLAG_W = 4,
    parameter int MC_TMO = 8,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_s,
    input  logic              ex_cond_pass,
    input  logic              ex_multi,
    input  logic [FLAG_W-1:0] ex_flags,
    input  logic              mc_done,
    input  logic [FLAG_W-1:0] mc_flags,
    input  logic              msr_we,
    input  logic [FLAG_W-1:0] msr_data,
    input  logic              flush,
    input  logic              id_uses_flags,
    output logic [FLAG_W-1:0] sr_q,
    output logic [FLAG_W-1:0] sr_fwd,
    output logic              flag_stall,
    output logic              busy,
    output logic              err_tmo
);
    localparam int CNT_W = $clog2(MC_TMO + 1);
    sr_state_t         state_q, state_d;
    logic [FLAG_W-1:0] sr_d;
    logic              err_tmo_q, err_tmo_d;
    logic              upd, idle, tmo_load, tmo_expire;
    logic [CNT_W-1:0]  tmo_cnt;
    assign upd  = ex_valid & ex_s & ex_cond_pass & ~flush;
    assign idle = state_q == SR_IDLE;
    sr_tmo_counter #(.MC_TMO(MC_TMO), .CNT_W(CNT_W)) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmo_load),
        .dec    (~idle),
        .cnt_q  (tmo_cnt),
        .expire (tmo_expire)
    );
    // next-state and flag commit; WAIT exits on done > flush > msr > timeout
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        err_tmo_d = 1'b0;
        tmo_load  = 1'b0;
        if (idle) begin
            sr_d = msr_we ? msr_data : (upd && !ex_multi) ? ex_flags : sr_q;
            if (upd && ex_multi) begin
                state_d  = SR_WAIT;
                tmo_load = 1'b1;
            end
        end else if (mc_done) begin
            sr_d    = mc_flags;
            state_d = SR_IDLE;
        end else if (flush) begin
            state_d = SR_IDLE;
        end else if (msr_we) begin
            sr_d    = msr_data;
            state_d = SR_IDLE;
        end else if (tmo_expire) begin
            err_tmo_d = 1'b1;
            state_d   = SR_IDLE;
        end
    end
    // state, status and timeout-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SR_IDLE;
            sr_q      <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            err_tmo_q <= err_tmo_d;
        end
    end
    // bypassed flag view and stall while flags are not yet resolvable
    always_comb begin
        sr_fwd = idle ? (msr_we ? msr_data : (BYPASS && upd && !ex_multi) ? ex_flags : sr_q)
                      : (mc_done ? mc_flags : sr_q);
        flag_stall = id_uses_flags & ((~idle & ~mc_done) | (idle & upd & ex_multi) |
                                      (~BYPASS & idle & upd & ~ex_multi));
    end
    assign busy    = ~idle;
    assign err_tmo = err_tmo_q;
    logic unused;
    assign unused = ^tmo_cnt;
endmodule

// File: tb/tb_status_reg_ctrl.sv
// tb_status_reg_ctrl: random and directed checks of status_reg_ctrl against a flag model
module tb_status_reg_ctrl;
    localparam int MC_TMO = 8;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ex_valid = 0, ex_s = 0, ex_cond_pass = 0, ex_multi = 0;
    logic [3:0] ex_flags = 0, mc_flags = 0, msr_data = 0;
    logic       mc_done = 0, msr_we = 0, flush = 0, id_uses_flags = 0;
    logic [3:0] sr_q, sr_fwd, sr_q_nb, sr_fwd_nb;
    logic       flag_stall, busy, err_tmo, flag_stall_nb, busy_nb, err_tmo_nb;
    int         n_checks = 0, n_fail = 0;
    logic [3:0] m_sr;
    bit         m_pend, m_err;
    int         m_waited;

    always #5 clk = ~clk;

    status_reg_ctrl #(.MC_TMO(MC_TMO), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_s(ex_s),
        .ex_cond_pass(ex_cond_pass), .ex_multi(ex_multi), .ex_flags(ex_flags),
        .mc_done(mc_done), .mc_flags(mc_flags), .msr_we(msr_we), .msr_data(msr_data),
        .flush(flush), .id_uses_flags(id_uses_flags), .sr_q(sr_q), .sr_fwd(sr_fwd),
        .flag_stall(flag_stall), .busy(busy), .err_tmo(err_tmo));

    status_reg_ctrl #(.MC_TMO(MC_TMO), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_s(ex_s),
        .ex_cond_pass(ex_cond_pass), .ex_multi(ex_multi), .ex_flags(ex_flags),
        .mc_done(mc_done), .mc_flags(mc_flags), .msr_we(msr_we), .msr_data(msr_data),
        .flush(flush), .id_uses_flags(id_uses_flags), .sr_q(sr_q_nb), .sr_fwd(sr_fwd_nb),
        .flag_stall(flag_stall_nb), .busy(busy_nb), .err_tmo(err_tmo_nb));

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sr = 4'h0; m_pend = 0; m_err = 0; m_waited = 0;
    endtask

    task automatic quiet();
        ex_valid = 0; ex_s = 0; ex_cond_pass = 0; ex_multi = 0; ex_flags = 0;
        mc_done = 0; mc_flags = 0; msr_we = 0; msr_data = 0; flush = 0; id_uses_flags = 0;
    endtask

    task automatic set_upd(input logic [3:0] f, input bit multi);
        ex_valid = 1; ex_s = 1; ex_cond_pass = 1; ex_multi = multi; ex_flags = f;
    endtask

    // compare both instances against the model, then advance the model across one edge
    task automatic step();
        bit         upd, exp_stall, exp_stall_nb;
        logic [3:0] exp_fwd, exp_fwd_nb;
        #1;
        upd = ex_valid && ex_s && ex_cond_pass && !flush;
        if (!m_pend) begin
            exp_fwd    = msr_we ? msr_data : (upd && !ex_multi) ? ex_flags : m_sr;
            exp_fwd_nb = msr_we ? msr_data : m_sr;
            exp_stall    = id_uses_flags && upd && ex_multi;
            exp_stall_nb = id_uses_flags && upd;
        end else begin
            exp_fwd    = mc_done ? mc_flags : m_sr;
            exp_fwd_nb = exp_fwd;
            exp_stall    = id_uses_flags && !mc_done;
            exp_stall_nb = exp_stall;
        end
        check("sr_q", {4'h0, sr_q}, {4'h0, m_sr});
        check("sr_fwd", {4'h0, sr_fwd}, {4'h0, exp_fwd});
        check("flag_stall", {7'h0, flag_stall}, {7'h0, exp_stall});
        check("busy", {7'h0, busy}, {7'h0, m_pend});
        check("err_tmo", {7'h0, err_tmo}, {7'h0, m_err});
        check("nb_sr_q", {4'h0, sr_q_nb}, {4'h0, m_sr});
        check("nb_sr_fwd", {4'h0, sr_fwd_nb}, {4'h0, exp_fwd_nb});
        check("nb_flag_stall", {7'h0, flag_stall_nb}, {7'h0, exp_stall_nb});
        check("nb_err_tmo", {7'h0, err_tmo_nb}, {7'h0, m_err});
        m_err = 0;
        if (!m_pend) begin
            if (msr_we) m_sr = msr_data;
            else if (upd && !ex_multi) m_sr = ex_flags;
            if (upd && ex_multi) begin
                m_pend = 1;
                m_waited = 0;
            end
        end else if (mc_done) begin
            m_sr = mc_flags; m_pend = 0;
        end else if (flush) begin
            m_pend = 0;
        end else if (msr_we) begin
            m_sr = msr_data; m_pend = 0;
        end else if (m_waited == MC_TMO - 1) begin
            m_err = 1; m_pend = 0;
        end else begin
            m_waited++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_sr_q", {4'h0, sr_q}, 8'h0);
        check("rst_busy", {7'h0, busy}, 8'h0);
        rst_n = 1;
        // single-cycle ALU update with same-cycle bypass
        set_upd(4'b0101, 0); id_uses_flags = 1;
        step();
        quiet();
        step();
        check("alu_sr_q", {4'h0, sr_q}, 8'h05);
        // condition fail and flush leave flags alone
        set_upd(4'hF, 0); ex_cond_pass = 0; step();
        set_upd(4'hF, 0); flush = 1; step();
        quiet(); step();
        check("nopass_sr_q", {4'h0, sr_q}, 8'h05);
        // multi-cycle producer
        set_upd(4'h0, 1); id_uses_flags = 1; step();
        quiet(); id_uses_flags = 1; step(); step(); step();
        mc_done = 1; mc_flags = 4'b1000; step();
        quiet(); step();
        check("mc_sr_q", {4'h0, sr_q}, 8'h08);
        // timeout with no completion
        set_upd(4'h0, 1); step();
        quiet();
        n = 0;
        while (!err_tmo && n < 20) begin
            step();
            n++;
        end
        check("tmo_cycles", 8'(n), 8'(MC_TMO));
        check("tmo_sr_q", {4'h0, sr_q}, 8'h08);
        check("tmo_busy", {7'h0, busy}, 8'h0);
        quiet(); step();
        // msr write beats ALU update; no-bypass instance stalls
        set_upd(4'b1100, 0); msr_we = 1; msr_data = 4'b0011; id_uses_flags = 1;
        step();
        quiet(); step();
        check("prio_sr_q", {4'h0, sr_q}, 8'h03);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            ex_valid = $urandom_range(0, 3) != 0;
            ex_s = 1'($urandom_range(0, 1));
            ex_cond_pass = $urandom_range(0, 3) != 0;
            ex_multi = $urandom_range(0, 3) == 0;
            ex_flags = 4'($urandom);
            mc_done = $urandom_range(0, 11) == 0;
            mc_flags = 4'($urandom);
            msr_we = $urandom_range(0, 11) == 0;
            msr_data = 4'($urandom);
            flush = $urandom_range(0, 11) == 0;
            id_uses_flags = 1'($urandom_range(0, 1));
            step();
        end
        // asynchronous reset in the middle of a cycle, while waiting
        quiet(); set_upd(4'h0, 1); step();
        quiet(); id_uses_flags = 1; step();
        #2 rst_n = 0;
        #1;
        check("arst_sr_q", {4'h0, sr_q}, 8'h0);
        check("arst_sr_fwd", {4'h0, sr_fwd}, 8'h0);
        check("arst_stall", {7'h0, flag_stall}, 8'h0);
        check("arst_busy", {7'h0, busy}, 8'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
